// File: rtl/mux_decoder_if.sv
// Bus bundle between the encoder stream, the mux decoder and its downstream consumer.
interface mux_decoder_if #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
);
  logic [7:0]               enc_data;
  logic                     enc_datavalid;
  logic [7:0]               dec_data;
  logic                     dec_datavalid;
  logic                     dec_ready;
  logic [$clog2(DEPTH):0]   fifo_level;
  logic [CNTW-1:0]          viol_cnt;
  logic                     ovf;
  logic                     sync_done;

  modport master (
    output enc_data, enc_datavalid, dec_ready,
    input  dec_data, dec_datavalid, fifo_level, viol_cnt, ovf, sync_done
  );

  modport slave (
    input  enc_data, enc_datavalid, dec_ready,
    output dec_data, dec_datavalid, fifo_level, viol_cnt, ovf, sync_done
  );
endinterface

// File: rtl/mux_decoder.sv
// Receive side of the mux encoder pipeline: masks the encoder's start-up garbage,
// checks the zero-when-invalid rule and buffers recovered beats in a small FIFO.
module mux_decoder #(
  parameter int LAT   = 7,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_decoder_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [0:0] {
    S_FLUSH = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_sync_done;

  logic [7:0]      r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [CNTW-1:0] r_viol_cnt;
  logic            r_ovf;

  logic            w_run;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_viol;

  // Flush window: encoder pipeline contents are unreset for LAT cycles after reset.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_FLUSH: begin
        if (r_cnt == CW'(LAT - 1)) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = r_cnt;
      end
      default: begin
        w_state_nxt = S_FLUSH;
        w_cnt_nxt   = {CW{1'b0}};
      end
    endcase
  end

  // FIFO control; a full FIFO still accepts a beat when the head leaves in the same cycle.
  always_comb begin
    w_run   = (r_state == S_RUN);
    w_full  = (r_level == LW'(DEPTH));
    w_empty = (r_level == {LW{1'b0}});
    w_pop   = !w_empty && bus.dec_ready;
    w_push  = w_run && bus.enc_datavalid && (!w_full || w_pop);
    w_drop  = w_run && bus.enc_datavalid && w_full && !w_pop;
    w_viol  = w_run && !bus.enc_datavalid && (bus.enc_data != 8'h00);
  end

  // State register and registered sync indication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_FLUSH;
      r_cnt       <= {CW{1'b0}};
      r_sync_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sync_done <= (w_state_nxt == S_RUN);
    end
  end

  // FIFO storage, pointers, occupancy and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
      r_wr_ptr   <= {PW{1'b0}};
      r_rd_ptr   <= {PW{1'b0}};
      r_level    <= {LW{1'b0}};
      r_viol_cnt <= {CNTW{1'b0}};
      r_ovf      <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.enc_data;
        r_wr_ptr        <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + {{(LW-1){1'b0}}, 1'b1};
        2'b01:   r_level <= r_level - {{(LW-1){1'b0}}, 1'b1};
        default: r_level <= r_level;
      endcase
      if (w_viol && (r_viol_cnt != {CNTW{1'b1}})) begin
        r_viol_cnt <= r_viol_cnt + {{(CNTW-1){1'b0}}, 1'b1};
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.dec_data      = r_mem[r_rd_ptr];
  assign bus.dec_datavalid = !w_empty;
  assign bus.fifo_level    = r_level;
  assign bus.viol_cnt      = r_viol_cnt;
  assign bus.ovf           = r_ovf;
  assign bus.sync_done     = r_sync_done;

endmodule

// File: tb/tb_mux_decoder.sv
// Directed self-checking bench for mux_decoder: flush window, streaming,
// overflow, full push/pop, violation saturation and mid-stream reset.
module tb_mux_decoder;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mux_decoder_if #(.DEPTH(4), .CNTW(8)) bus ();

  mux_decoder #(.LAT(7), .DEPTH(4), .CNTW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enc_data = 8'hFF;
    bus.enc_datavalid = 1'b1;
    bus.dec_ready = 1'b0;
    tick();
    tick();
    checks++; if (bus.dec_datavalid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bus.dec_datavalid); end
    checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", bus.fifo_level); end
    checks++; if (bus.viol_cnt !== 8'd0) begin errors++; $display("FAIL reset_viol got=%0d exp=0", bus.viol_cnt); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", bus.ovf); end
    checks++; if (bus.sync_done !== 1'b0) begin errors++; $display("FAIL reset_sync got=%0b exp=0", bus.sync_done); end
    checks++; if (bus.dec_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", bus.dec_data); end
  endtask

  task automatic test_flush();
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++; if (bus.sync_done !== (k == 7)) begin errors++; $display("FAIL flush_sync k=%0d got=%0b exp=%0b", k, bus.sync_done, (k == 7)); end
      checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL flush_level k=%0d got=%0d exp=0", k, bus.fifo_level); end
    end
    checks++; if (bus.viol_cnt !== 8'd0) begin errors++; $display("FAIL flush_viol got=%0d exp=0", bus.viol_cnt); end
  endtask

  task automatic test_stream();
    logic [7:0] beats [3];
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.enc_data = beats[i];
      bus.enc_datavalid = 1'b1;
      tick();
      checks++; if (bus.dec_data !== beats[i] || bus.dec_datavalid !== 1'b1) begin errors++; $display("FAIL stream_data i=%0d got=%h/%0b exp=%h/1", i, bus.dec_data, bus.dec_datavalid, beats[i]); end
      checks++; if (bus.fifo_level !== 3'd1) begin errors++; $display("FAIL stream_level i=%0d got=%0d exp=1", i, bus.fifo_level); end
    end
    bus.enc_data = 8'h00;
    bus.enc_datavalid = 1'b0;
    tick();
    checks++; if (bus.dec_datavalid !== 1'b0 || bus.fifo_level !== 3'd0) begin errors++; $display("FAIL stream_drain got=%0b/%0d exp=0/0", bus.dec_datavalid, bus.fifo_level); end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] exp_v;
    bus.dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.enc_data = 8'hB0 + 8'(i);
      bus.enc_datavalid = 1'b1;
      tick();
    end
    checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL fpp_fill got=%0d exp=4", bus.fifo_level); end
    bus.enc_data = 8'hB4;
    bus.dec_ready = 1'b1;
    tick();
    checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL fpp_level got=%0d exp=4", bus.fifo_level); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL fpp_ovf got=%0b exp=0", bus.ovf); end
    bus.enc_data = 8'h00;
    bus.enc_datavalid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_v = 8'hB0 + 8'(i);
      checks++; if (bus.dec_data !== exp_v) begin errors++; $display("FAIL fpp_order i=%0d got=%h exp=%h", i, bus.dec_data, exp_v); end
      tick();
    end
    checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL fpp_empty got=%0d exp=0", bus.fifo_level); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_v;
    bus.dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.enc_data = 8'hA0 + 8'(i);
      bus.enc_datavalid = 1'b1;
      tick();
      if (i == 3) begin
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got=%0b exp=0", bus.ovf); end
      end
    end
    checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got=%0d exp=4", bus.fifo_level); end
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", bus.ovf); end
    tick();
    checks++; if (bus.dec_data !== 8'hA0) begin errors++; $display("FAIL ovf_hold got=%h exp=a0", bus.dec_data); end
    bus.enc_data = 8'h00;
    bus.enc_datavalid = 1'b0;
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_v = 8'hA0 + 8'(i);
      checks++; if (bus.dec_data !== exp_v) begin errors++; $display("FAIL ovf_drain i=%0d got=%h exp=%h", i, bus.dec_data, exp_v); end
      tick();
    end
    checks++; if (bus.dec_datavalid !== 1'b0 || bus.fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_empty got=%0b/%0d exp=0/0", bus.dec_datavalid, bus.fifo_level); end
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", bus.ovf); end
  endtask

  task automatic test_violation();
    bus.dec_ready = 1'b0;
    bus.enc_datavalid = 1'b0;
    bus.enc_data = 8'h05;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 1 || i == 254 || i == 255 || i == 300) begin
        checks++; if (bus.viol_cnt !== ((i > 255) ? 8'd255 : 8'(i))) begin errors++; $display("FAIL viol_cnt i=%0d got=%0d exp=%0d", i, bus.viol_cnt, (i > 255) ? 255 : i); end
      end
    end
    checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL viol_nowrite got=%0d exp=0", bus.fifo_level); end
    bus.enc_data = 8'h00;
    tick();
    checks++; if (bus.viol_cnt !== 8'd255) begin errors++; $display("FAIL viol_zero got=%0d exp=255", bus.viol_cnt); end
  endtask

  task automatic test_midreset();
    bus.dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.enc_data = 8'hC0 + 8'(i);
      bus.enc_datavalid = 1'b1;
      tick();
    end
    checks++; if (bus.fifo_level !== 3'd3) begin errors++; $display("FAIL mrst_fill got=%0d exp=3", bus.fifo_level); end
    rst_n = 1'b0;
    bus.enc_data = 8'hC3;
    tick();
    rst_n = 1'b1;
    checks++; if (bus.dec_datavalid !== 1'b0 || bus.fifo_level !== 3'd0) begin errors++; $display("FAIL mrst_fifo got=%0b/%0d exp=0/0", bus.dec_datavalid, bus.fifo_level); end
    checks++; if (bus.viol_cnt !== 8'd0 || bus.ovf !== 1'b0) begin errors++; $display("FAIL mrst_flags got=%0d/%0b exp=0/0", bus.viol_cnt, bus.ovf); end
    checks++; if (bus.sync_done !== 1'b0) begin errors++; $display("FAIL mrst_sync got=%0b exp=0", bus.sync_done); end
    for (int k = 1; k <= 7; k++) begin
      bus.enc_data = 8'hD0 + 8'(k);
      tick();
      checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL mrst_flush k=%0d got=%0d exp=0", k, bus.fifo_level); end
    end
    checks++; if (bus.sync_done !== 1'b1) begin errors++; $display("FAIL mrst_syncup got=%0b exp=1", bus.sync_done); end
    bus.enc_data = 8'hE0;
    tick();
    checks++; if (bus.fifo_level !== 3'd1 || bus.dec_data !== 8'hE0) begin errors++; $display("FAIL mrst_first got=%0d/%h exp=1/e0", bus.fifo_level, bus.dec_data); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_flush();
    test_stream();
    test_full_pushpop();
    test_overflow();
    test_violation();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
